pift_taint_scanner: RTL and testbench
=====================================

Name: pift_taint_scanner

Overview:
Sequences periodic sampling of the taint_sum outputs produced by the PIFT dff/mem taint cells across the SoC. It scans NSRC sources round-robin, one per cycle, and accumulates a saturating total. It also tracks the most-tainted source and pushes one record per scan into a small FIFO drained by the sim trace/host over valid/ready. It is the single scheduler of taint-sum observation; cells stay untouched.

Parameters:
NSRC, 8, number of taint_sum sources scanned
SUM_W, 8, width of each source taint_sum (zero-extended if narrower)
ACC_W, 16, accumulator/total width (saturating)
PERIOD_W, 16, width of sampling period
FIFO_DEPTH, 4, record FIFO entries (power of 2, >=2)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
EN  in  1  enables periodic scanning
PERIOD  in  PERIOD_W  cycles between scan starts; 0 = periodic off
TRIG  in  1  one-cycle pulse forcing a scan
THRESH  in  ACC_W  alarm threshold on total
SRC_SUM  in  NSRC*SUM_W  packed source taint sums, source i at [i*SUM_W +: SUM_W]
REC_VALID  out  1  FIFO head valid
REC_READY  in  1  consumer accepts head
REC_TOTAL  out  ACC_W  saturated sum of all sources in the scan
REC_MAX  out  SUM_W  largest single source value
REC_MAXIDX  out  $clog2(NSRC)  index of REC_MAX, lowest index on tie
REC_SEQ  out  16  scan sequence number, wraps 0xFFFF->0
REC_OVER  out  1  REC_TOTAL >= THRESH
BUSY  out  1  FSM not in IDLE/WAIT
ALARM  out  1  sticky, set by any pushed or dropped record with OVER
DROP_CNT  out  16  records dropped on full FIFO, saturates at 0xFFFF

Behaviour:
- Reset (RST_N low, async): FSM=IDLE, countdown=0, acc/max/idx=0, seq=0, FIFO empty, REC_VALID=0, REC_* outputs=0, BUSY=0, ALARM=0, DROP_CNT=0, pending-trigger=0.
- States: IDLE, WAIT, SCAN, PUSH.
- IDLE: TRIG -> SCAN. Else EN && PERIOD!=0 -> WAIT with countdown=PERIOD-1.
- WAIT: countdown decrements each cycle. Reaching 0 -> SCAN. TRIG -> SCAN immediately. EN low or PERIOD==0 -> IDLE.
- SCAN: entry clears acc/max/idx, index=0. Each cycle samples source[index]: acc=sat(acc+src). If src>max, update max/idx (strict >, so ties keep the lower index). NSRC cycles, index 0..NSRC-1, then PUSH.
- PUSH (1 cycle): record {acc, max, idx, seq, acc>=THRESH}. FIFO not full: write. FIFO full: drop, DROP_CNT++ (saturating). seq increments in both cases. OVER sets ALARM either way.
- After PUSH: pending-trigger -> SCAN (clear pending). Else EN && PERIOD!=0 -> WAIT reloaded with PERIOD-1, measured from the PUSH cycle. Else IDLE.
- TRIG during SCAN/PUSH sets pending-trigger. Multiple TRIGs collapse to one.
- EN falling mid-scan: the scan completes and pushes. Only the next transition is affected.
- PERIOD/THRESH are sampled live: THRESH at PUSH, PERIOD at WAIT load.
- Latency: TRIG at cycle t (IDLE) -> SCAN cycles t+1..t+NSRC, PUSH t+NSRC+1, REC_VALID high at t+NSRC+2 if FIFO was empty.
- FIFO: first-word-fall-through, registered outputs. Pop on REC_VALID&&REC_READY. Simultaneous push and pop when full is allowed: the pop frees a slot, so no drop. REC_* hold stable while REC_VALID && !REC_READY.
- Saturation: acc clamps at 2^ACC_W-1 and never wraps.
- BUSY=1 in SCAN and PUSH.

Decomposition:
- Shared package pift_pkg: state enum {IDLE,WAIT,SCAN,PUSH}, record struct type, saturating-add function.
- One sub-module pift_rec_fifo: generic FWFT sync FIFO, WIDTH/DEPTH params, async active-low reset, full/empty flags, simultaneous push/pop when full.

Test Plan:
- Reset/trigger: NSRC=8, sources=1..8, pulse TRIG -> REC_VALID at t+10; TOTAL=36, MAX=8, MAXIDX=7, SEQ=0, OVER=0 with THRESH=100.
- Ties and saturation: ACC_W=8, all sources=0x40 -> TOTAL=0xFF, MAX=0x40, MAXIDX=0.
- Periodic: EN=1, PERIOD=20, REC_READY=1 -> scan starts every 20+NSRC+1 cycles, SEQ increments 0,1,2; PERIOD=0 mid-WAIT -> IDLE, no further records.
- Backpressure/drop: REC_READY=0, 6 triggered scans, DEPTH=4 -> 4 records held (SEQ 0..3), DROP_CNT=2, next accepted SEQ after drain is 6.
- Trigger collapse and alarm: 3 TRIG pulses during SCAN -> exactly one extra scan. THRESH=10, total 36 -> OVER=1, ALARM sticky until RST_N.
- Async reset mid-SCAN: RST_N low at index 4 -> all outputs 0 immediately, FIFO empty, SEQ restarts at 0.

Source files
------------

// File: rtl/pift_pkg.sv
`default_nettype none
// ============================================================================
// Module : pift_pkg
// Shared FSM state encoding and saturating-add helper for the taint scanner.
// Rev    : 1.0
// ============================================================================
package pift_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SCAN = 2'd2,
    PUSH = 2'd3
  } pift_state_t;

  // Operands are zero-extended to 32 bits; result clamps at lim.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    sat_add = (s > {1'b0, lim}) ? lim : s[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pift_rec_fifo.sv
`default_nettype none
// ============================================================================
// Module : pift_rec_fifo
// First-word-fall-through sync FIFO; push into a full FIFO succeeds when a pop
// happens in the same cycle.
// Rev    : 1.0
// ============================================================================
module pift_rec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == c_cw'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_dout  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + c_aw'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pift_taint_scanner.sv
`default_nettype none
// ============================================================================
// Module : pift_taint_scanner
// Round-robin sampler of PIFT taint sums; pushes one summary record per scan.
// Rev    : 1.0
// ============================================================================
module pift_taint_scanner
  import pift_pkg::*;
#(
  parameter int NSRC       = 8,
  parameter int SUM_W      = 8,
  parameter int ACC_W      = 16,
  parameter int PERIOD_W   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     EN,
  input  logic [PERIOD_W-1:0]      PERIOD,
  input  logic                     TRIG,
  input  logic [ACC_W-1:0]         THRESH,
  input  logic [NSRC*SUM_W-1:0]    SRC_SUM,
  output logic                     REC_VALID,
  input  logic                     REC_READY,
  output logic [ACC_W-1:0]         REC_TOTAL,
  output logic [SUM_W-1:0]         REC_MAX,
  output logic [$clog2(NSRC)-1:0]  REC_MAXIDX,
  output logic [15:0]              REC_SEQ,
  output logic                     REC_OVER,
  output logic                     BUSY,
  output logic                     ALARM,
  output logic [15:0]              DROP_CNT
);
  localparam int                 c_idx_w    = $clog2(NSRC);
  localparam int                 c_rec_w    = ACC_W + SUM_W + c_idx_w + 16 + 1;
  localparam logic [31:0]        c_acc_max  = 32'((64'd1 << ACC_W) - 64'd1);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NSRC - 1);

  pift_state_t          r_state;
  logic [PERIOD_W-1:0]  r_cnt;
  logic [ACC_W-1:0]     r_acc;
  logic [SUM_W-1:0]     r_max;
  logic [c_idx_w-1:0]   r_max_idx;
  logic [c_idx_w-1:0]   r_scan_idx;
  logic [15:0]          r_seq;
  logic [15:0]          r_drop;
  logic                 r_pend;
  logic                 r_alarm;

  logic [SUM_W-1:0]     w_src;
  logic                 w_periodic;
  logic                 w_scan_start;
  logic                 w_over;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;
  logic [c_rec_w-1:0]   w_rec_in;
  logic [c_rec_w-1:0]   w_rec_out;

  assign w_src      = SRC_SUM[r_scan_idx*SUM_W +: SUM_W];
  assign w_periodic = EN && (PERIOD != '0);
  assign w_over     = (r_acc >= THRESH);
  assign w_push     = (r_state == PUSH);
  // A full FIFO only drops when the consumer is not freeing the head this cycle.
  assign w_drop     = w_push && w_full && !REC_READY;

  always_comb begin
    w_scan_start = 1'b0;
    case (r_state)
      IDLE:    w_scan_start = TRIG;
      WAIT:    w_scan_start = TRIG || (w_periodic && (r_cnt == '0));
      PUSH:    w_scan_start = r_pend || TRIG;
      default: w_scan_start = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_max      <= '0;
      r_max_idx  <= '0;
      r_scan_idx <= '0;
      r_seq      <= '0;
      r_drop     <= '0;
      r_pend     <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_scan_start) begin
            r_state <= SCAN;
          end else if (w_periodic) begin
            r_state <= WAIT;
            r_cnt   <= PERIOD - PERIOD_W'(1);
          end
        end
        WAIT: begin
          if (w_scan_start)     r_state <= SCAN;
          else if (!w_periodic) r_state <= IDLE;
          else                  r_cnt   <= r_cnt - PERIOD_W'(1);
        end
        SCAN: begin
          if (TRIG) r_pend <= 1'b1;
          r_acc <= ACC_W'(sat_add(32'(r_acc), 32'(w_src), c_acc_max));
          if (w_src > r_max) begin
            r_max     <= w_src;
            r_max_idx <= r_scan_idx;
          end
          r_scan_idx <= r_scan_idx + c_idx_w'(1);
          if (r_scan_idx == c_last_idx) r_state <= PUSH;
        end
        PUSH: begin
          r_seq <= r_seq + 16'd1;
          if (w_over) r_alarm <= 1'b1;
          if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
          if (w_scan_start) begin
            r_state <= SCAN;
            r_pend  <= 1'b0;
          end else if (w_periodic) begin
            r_state <= WAIT;
            r_cnt   <= PERIOD - PERIOD_W'(1);
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_scan_start) begin
        r_acc      <= '0;
        r_max      <= '0;
        r_max_idx  <= '0;
        r_scan_idx <= '0;
      end
    end
  end

  assign w_rec_in = {w_over, r_seq, r_max_idx, r_max, r_acc};

  pift_rec_fifo #(
    .WIDTH (c_rec_w),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .i_push  (w_push),
    .i_pop   (REC_READY),
    .i_din   (w_rec_in),
    .o_dout  (w_rec_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {REC_OVER, REC_SEQ, REC_MAXIDX, REC_MAX, REC_TOTAL} = w_rec_out;
  assign REC_VALID = !w_empty;
  assign BUSY      = (r_state == SCAN) || (r_state == PUSH);
  assign ALARM     = r_alarm;
  assign DROP_CNT  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_pift_taint_scanner.sv
`default_nettype none
// ============================================================================
// Module : tb_pift_taint_scanner
// Directed + random checks of pift_taint_scanner against a record-level model.
// Rev    : 1.0
// ============================================================================
module tb_pift_taint_scanner;

  typedef struct packed {
    logic [15:0] total;
    logic [7:0]  mx;
    logic [2:0]  idx;
    logic [15:0] seq;
    logic        over;
  } rec_t;

  logic        CLK = 1'b0;
  logic        RST_N, EN, TRIG, REC_READY, sat_ready;
  logic [15:0] PERIOD, THRESH;
  logic [7:0]  sat_thresh;
  logic [7:0]  src [8];
  logic [63:0] src_sum;
  logic [63:0] sat_src;

  logic        REC_VALID, REC_OVER, BUSY, ALARM;
  logic [15:0] REC_TOTAL, REC_SEQ, DROP_CNT;
  logic [7:0]  REC_MAX;
  logic [2:0]  REC_MAXIDX;

  logic        sat_valid, sat_over, sat_busy, sat_alarm;
  logic [7:0]  sat_total, sat_max;
  logic [2:0]  sat_idx;
  logic [15:0] sat_seq, sat_drop;

  int          n_checks = 0;
  int          n_err    = 0;
  rec_t        exp_q [$];
  logic [15:0] seq_m, drop_m;
  logic        alarm_m;

  always #5 CLK = ~CLK;

  always_comb begin
    src_sum = '0;
    for (int i = 0; i < 8; i++) src_sum[i*8 +: 8] = src[i];
  end

  pift_taint_scanner dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .PERIOD(PERIOD), .TRIG(TRIG),
    .THRESH(THRESH), .SRC_SUM(src_sum), .REC_VALID(REC_VALID),
    .REC_READY(REC_READY), .REC_TOTAL(REC_TOTAL), .REC_MAX(REC_MAX),
    .REC_MAXIDX(REC_MAXIDX), .REC_SEQ(REC_SEQ), .REC_OVER(REC_OVER),
    .BUSY(BUSY), .ALARM(ALARM), .DROP_CNT(DROP_CNT)
  );

  // Narrow accumulator instance for the saturation case.
  pift_taint_scanner #(.ACC_W(8)) dut_sat (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .PERIOD(PERIOD), .TRIG(TRIG),
    .THRESH(sat_thresh), .SRC_SUM(sat_src), .REC_VALID(sat_valid),
    .REC_READY(sat_ready), .REC_TOTAL(sat_total), .REC_MAX(sat_max),
    .REC_MAXIDX(sat_idx), .REC_SEQ(sat_seq), .REC_OVER(sat_over),
    .BUSY(sat_busy), .ALARM(sat_alarm), .DROP_CNT(sat_drop)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t model_rec();
    rec_t r;
    int   sum = 0;
    int   mx  = 0;
    int   mi  = 0;
    for (int i = 0; i < 8; i++) begin
      sum += int'(src[i]);
      if (int'(src[i]) > mx) mx = int'(src[i]);
    end
    for (int i = 7; i >= 0; i--) if (int'(src[i]) == mx) mi = i;
    r.total = (sum > 65535) ? 16'hFFFF : 16'(sum);
    r.mx    = 8'(mx);
    r.idx   = 3'(mi);
    r.seq   = seq_m;
    r.over  = (r.total >= THRESH);
    return r;
  endfunction

  task automatic model_push();
    rec_t r;
    r = model_rec();
    if (exp_q.size() < 4) exp_q.push_back(r);
    else if (drop_m != 16'hFFFF) drop_m++;
    seq_m++;
    alarm_m |= r.over;
  endtask

  task automatic model_reset();
    exp_q.delete();
    seq_m   = '0;
    drop_m  = '0;
    alarm_m = 1'b0;
  endtask

  task automatic do_scan();
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
    model_push();
    repeat (9) tick();
  endtask

  task automatic pop_check(input string tag);
    rec_t e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    check({tag, ".valid"}, 32'(REC_VALID), 32'd1);
    check({tag, ".total"}, 32'(REC_TOTAL), 32'(e.total));
    check({tag, ".max"},   32'(REC_MAX),   32'(e.mx));
    check({tag, ".idx"},   32'(REC_MAXIDX), 32'(e.idx));
    check({tag, ".seq"},   32'(REC_SEQ),   32'(e.seq));
    check({tag, ".over"},  32'(REC_OVER),  32'(e.over));
    REC_READY = 1'b1;
    tick();
    REC_READY = 1'b0;
  endtask

  task automatic rand_src(input int hi);
    for (int i = 0; i < 8; i++) src[i] = 8'($urandom_range(0, hi));
  endtask

  initial begin
    int   starts [$];
    int   n_rec;
    int   extra;
    logic prev_busy;
    rec_t r;

    RST_N = 1'b0; EN = 1'b0; TRIG = 1'b0; REC_READY = 1'b0; sat_ready = 1'b0;
    PERIOD = '0; THRESH = 16'd100; sat_thresh = 8'hF0; sat_src = {8{8'h40}};
    for (int i = 0; i < 8; i++) src[i] = 8'(i + 1);
    model_reset();
    repeat (2) tick();
    RST_N = 1'b1;
    tick();

    check("rst.valid", 32'(REC_VALID), 32'd0);
    check("rst.busy",  32'(BUSY),      32'd0);
    check("rst.alarm", 32'(ALARM),     32'd0);
    check("rst.drop",  32'(DROP_CNT),  32'd0);
    check("rst.total", 32'(REC_TOTAL), 32'd0);
    check("rst.seq",   32'(REC_SEQ),   32'd0);

    // Trigger latency: record visible NSRC+2 cycles after the TRIG cycle.
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
    model_push();
    check("lat.busy_scan", 32'(BUSY), 32'd1);
    repeat (8) tick();
    check("lat.valid_push", 32'(REC_VALID), 32'd0);
    check("lat.busy_push",  32'(BUSY),      32'd1);
    tick();
    check("lat.valid", 32'(REC_VALID), 32'd1);
    check("lat.busy_done", 32'(BUSY), 32'd0);
    check("lat.total36", 32'(REC_TOTAL), 32'd36);
    check("sat.valid", 32'(sat_valid), 32'd1);
    check("sat.total", 32'(sat_total), 32'hFF);
    check("sat.max",   32'(sat_max),   32'h40);
    check("sat.idx",   32'(sat_idx),   32'd0);
    check("sat.seq",   32'(sat_seq),   32'd0);
    check("sat.over",  32'(sat_over),  32'd1);
    check("sat.alarm", 32'(sat_alarm), 32'd1);
    check("sat.drop",  32'(sat_drop),  32'd0);
    check("sat.busy",  32'(sat_busy),  32'd0);
    pop_check("basic");

    // Random scans; odd iterations use a narrow value range to force ties.
    for (int it = 0; it < 6; it++) begin
      rand_src((it % 2 != 0) ? 3 : 255);
      THRESH = 16'($urandom_range(0, 1200));
      do_scan();
      pop_check("rand");
    end
    check("rand.alarm", 32'(ALARM), 32'(alarm_m));
    check("rand.drop",  32'(DROP_CNT), 32'(drop_m));

    // Three TRIG pulses while scanning collapse into one extra scan.
    for (int i = 0; i < 8; i++) src[i] = 8'(i + 1);
    THRESH = 16'd10;
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
    model_push();
    for (int k = 0; k < 3; k++) begin
      tick();
      TRIG = 1'b1;
      tick();
      TRIG = 1'b0;
    end
    model_push();
    repeat (30) tick();
    check("coll.busy", 32'(BUSY), 32'd0);
    pop_check("coll0");
    pop_check("coll1");
    check("coll.empty", 32'(REC_VALID), 32'd0);
    check("coll.alarm", 32'(ALARM), 32'd1);
    for (int i = 0; i < 8; i++) src[i] = 8'd0;
    do_scan();
    check("sticky.alarm", 32'(ALARM), 32'd1);
    check("sticky.valid", 32'(REC_VALID), 32'd1);

    // Asynchronous reset in the middle of a scan.
    rand_src(255);
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
    repeat (4) tick();
    check("arst.busy_before", 32'(BUSY), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    check("arst.valid", 32'(REC_VALID), 32'd0);
    check("arst.busy",  32'(BUSY),      32'd0);
    check("arst.alarm", 32'(ALARM),     32'd0);
    check("arst.drop",  32'(DROP_CNT),  32'd0);
    check("arst.total", 32'(REC_TOTAL), 32'd0);
    check("arst.seq",   32'(REC_SEQ),   32'd0);
    model_reset();
    #1 RST_N = 1'b1;
    tick();

    // Backpressure: six scans into a four-deep FIFO.
    THRESH = 16'hFFFF;
    for (int k = 0; k < 6; k++) begin
      rand_src(255);
      do_scan();
    end
    check("bp.drop", 32'(DROP_CNT), 32'(drop_m));
    check("bp.drop2", 32'(DROP_CNT), 32'd2);
    for (int k = 0; k < 4; k++) pop_check("bp");
    check("bp.empty", 32'(REC_VALID), 32'd0);
    rand_src(255);
    do_scan();
    check("bp.seq6", 32'(REC_SEQ), 32'd6);
    pop_check("bp.next");

    // Periodic scanning with an always-ready consumer.
    rand_src(255);
    REC_READY = 1'b1;
    PERIOD = 16'd20;
    EN = 1'b1;
    prev_busy = 1'b0;
    n_rec = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      tick();
      if (BUSY && !prev_busy) starts.push_back(cyc);
      prev_busy = BUSY;
      if (REC_VALID) begin
        r = model_rec();
        seq_m++;
        n_rec++;
        check("per.total", 32'(REC_TOTAL), 32'(r.total));
        check("per.max",   32'(REC_MAX),   32'(r.mx));
        check("per.idx",   32'(REC_MAXIDX), 32'(r.idx));
        check("per.seq",   32'(REC_SEQ),   32'(r.seq));
      end
    end
    check("per.nstarts", 32'(starts.size()), 32'd3);
    check("per.nrec", 32'(n_rec), 32'd3);
    if (starts.size() >= 3) begin
      check("per.first",  32'(starts[0]), 32'd20);
      check("per.gap0",   32'(starts[1] - starts[0]), 32'd29);
      check("per.gap1",   32'(starts[2] - starts[1]), 32'd29);
    end
    PERIOD = 16'd0;
    extra = 0;
    repeat (60) begin
      tick();
      if (REC_VALID || BUSY) extra++;
    end
    check("per.off", 32'(extra), 32'd0);
    check("end.drop",  32'(DROP_CNT), 32'(drop_m));
    check("end.alarm", 32'(ALARM), 32'(alarm_m));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
